// File: rtl/segment_arbiter.sv
// Single-direction (low-to-high) arbiter for a segmented interposer bus.
// Packs non-overlapping request spans greedily from a rotating pointer and holds each grant for a fixed window.
module segment_arbiter #(
    parameter int NODE_COUNT          = 8,
    parameter int NODE_COUNT_DIGIT    = 3,
    parameter int NODE_TO_ARBITER_SIG = NODE_COUNT_DIGIT + 1,
    parameter int XFER_CYCLES         = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NODE_COUNT*NODE_TO_ARBITER_SIG-1:0] request_port,
    output logic [NODE_COUNT*3-1:0]                   control_port,
    output logic                                      busy
);

    localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NODE_COUNT_DIGIT-1:0] ptr_q, ptr_d;
    logic [NODE_COUNT*3-1:0]     ctrl_q, ctrl_d;
    logic                        busy_q, busy_d;

    logic [NODE_COUNT-1:0]          send_s, recv_s, byp_s, occ_s, span_s;
    logic [NODE_TO_ARBITER_SIG-1:0] fld_s;
    logic                           accept_s, any_s;
    logic [NODE_COUNT_DIGIT-1:0]    first_s;
    int                             src_s, dst_s;

    // Greedy scan from ptr: a span is taken only if none of its nodes is already claimed.
    always_comb begin
        send_s   = '0;
        recv_s   = '0;
        byp_s    = '0;
        occ_s    = '0;
        span_s   = '0;
        fld_s    = '0;
        accept_s = 1'b0;
        any_s    = 1'b0;
        first_s  = '0;
        src_s    = 0;
        dst_s    = 0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            src_s = (int'(ptr_q) + i) % NODE_COUNT;
            fld_s = request_port[src_s*NODE_TO_ARBITER_SIG +: NODE_TO_ARBITER_SIG];
            dst_s = int'(fld_s[NODE_COUNT_DIGIT-1:0]);
            for (int k = 0; k < NODE_COUNT; k++) begin
                span_s[k] = (k >= src_s) && (k <= dst_s);
            end
            accept_s = fld_s[NODE_TO_ARBITER_SIG-1] && (dst_s > src_s) &&
                       (dst_s < NODE_COUNT) && ((span_s & occ_s) == '0);
            occ_s = occ_s | (accept_s ? span_s : '0);
            for (int k = 0; k < NODE_COUNT; k++) begin
                send_s[k] = send_s[k] | (accept_s && (k == src_s));
                recv_s[k] = recv_s[k] | (accept_s && (k == dst_s));
                byp_s[k]  = byp_s[k]  | (accept_s && (k > src_s) && (k < dst_s));
            end
            first_s = (accept_s && !any_s) ? NODE_COUNT_DIGIT'((src_s + 1) % NODE_COUNT) : first_s;
            any_s   = any_s | accept_s;
        end
    end

    // Window sequencing: sample only in IDLE, hold the grant, then one quiet GAP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ctrl_d  = ctrl_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = GRANT;
                    cnt_d   = CW'(XFER_CYCLES - 1);
                    ptr_d   = first_s;
                    ctrl_d  = {send_s, recv_s, byp_s};
                    busy_d  = 1'b1;
                end else begin
                    ctrl_d = '0;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    ctrl_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
                ctrl_d  = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ctrl_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
        end
    end

    assign control_port = ctrl_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_segment_arbiter.sv
// Directed self-checking bench for segment_arbiter (NODE_COUNT=8, XFER_CYCLES=2).
// Expected control words are {send, receive, bypass}, hand-computed per scenario.
module tb_segment_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] request_port;
    logic [23:0] control_port;
    logic        busy;
    int          checks;
    int          errors;

    segment_arbiter #(
        .NODE_COUNT(8),
        .NODE_COUNT_DIGIT(3),
        .NODE_TO_ARBITER_SIG(4),
        .XFER_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .request_port(request_port),
        .control_port(control_port),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fld(input int node, input int dest);
        logic [31:0] f;
        f = 32'h8 | (32'(dest) & 32'h7);
        return f << (4 * node);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset        = 1'b0;
        request_port = 32'h0;
        tick();
        tick();
        check({tag, "_ctrl"}, 32'(control_port), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ptr"}, 32'(dut.ptr_q), 32'h0);
        reset = 1'b1;
    endtask

    // Present req just after an edge, then walk the two GRANT cycles, GAP and return to IDLE.
    task automatic window(input string tag, input logic [31:0] req, input logic [23:0] exp,
                          input int exp_ptr, input bit hold);
        request_port = req;
        tick();
        check({tag, "_g1_ctrl"}, 32'(control_port), 32'(exp));
        check({tag, "_g1_busy"}, 32'(busy), 32'h1);
        if (!hold) request_port = 32'h0;
        tick();
        check({tag, "_g2_ctrl"}, 32'(control_port), 32'(exp));
        check({tag, "_g2_busy"}, 32'(busy), 32'h1);
        tick();
        check({tag, "_gap_ctrl"}, 32'(control_port), 32'h0);
        check({tag, "_gap_busy"}, 32'(busy), 32'h0);
        tick();
        check({tag, "_idle_ctrl"}, 32'(control_port), 32'h0);
        check({tag, "_ptr"}, 32'(dut.ptr_q), 32'(exp_ptr));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        request_port = 32'h0;

        do_reset("rst0");

        // Single request 1->5.
        window("single", fld(1, 5), 24'h02201C, 2, 1'b0);

        // Disjoint spans 0->2 and 4->7 share one window.
        do_reset("rst1");
        window("disjoint", fld(0, 2) | fld(4, 7), 24'h118462, 1, 1'b0);

        // Conflicting spans held: 0->4 first, then 2->6 from ptr=1.
        do_reset("rst2");
        window("conflict_a", fld(0, 4) | fld(2, 6), 24'h01100E, 1, 1'b1);
        window("conflict_b", fld(0, 4) | fld(2, 6), 24'h044038, 3, 1'b0);

        // Adjacent spans share an endpoint node, so every other one packs.
        do_reset("rst3");
        window("adjacent", fld(0, 1) | fld(1, 2) | fld(2, 3) | fld(3, 4) |
                           fld(4, 5) | fld(5, 6) | fld(6, 7), 24'h55AA00, 1, 1'b0);

        // From ptr=1, node1 wins and node0's full-width span is blocked.
        window("scan_order", fld(0, 7) | fld(1, 2), 24'h020400, 2, 1'b0);

        // Ineligible requests: backwards and zero-length.
        do_reset("rst4");
        request_port = fld(5, 3);
        tick();
        tick();
        check("backward_busy", 32'(busy), 32'h0);
        check("backward_ctrl", 32'(control_port), 32'h0);
        check("backward_ptr", 32'(dut.ptr_q), 32'h0);
        request_port = fld(3, 3);
        tick();
        tick();
        check("selfdest_busy", 32'(busy), 32'h0);
        check("selfdest_ctrl", 32'(control_port), 32'h0);
        check("selfdest_ptr", 32'(dut.ptr_q), 32'h0);
        request_port = 32'h0;

        // Reset asserted in the first GRANT cycle aborts the window.
        request_port = fld(1, 5);
        tick();
        check("abort_g1_ctrl", 32'(control_port), 32'h02201C);
        request_port = 32'h0;
        reset        = 1'b0;
        tick();
        check("abort_ctrl", 32'(control_port), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ptr", 32'(dut.ptr_q), 32'h0);
        reset = 1'b1;
        tick();
        tick();
        check("abort_noresume_ctrl", 32'(control_port), 32'h0);
        check("abort_noresume_busy", 32'(busy), 32'h0);

        // Sampling is live on the first edge after reset release.
        request_port = fld(2, 3);
        tick();
        check("post_reset_ctrl", 32'(control_port), 32'h040800);
        check("post_reset_busy", 32'(busy), 32'h1);
        request_port = 32'h0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
